// File: rtl/cone_pkg.sv
// Shared types and default constants for the cone checker.
package cone_pkg;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        CHECK = 2'd1,
        FAULT = 2'd2
    } cone_state_e;

    localparam int CONE_LATENCY = 2;
    localparam int CONE_CNT_W   = 8;

endpackage

// File: rtl/cone_delay_line.sv
// LATENCY-deep shift register; q is the value of d captured LATENCY edges ago.
module cone_delay_line
    import cone_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int LATENCY = CONE_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_taps [LATENCY];

    // Shift on every edge; tap 0 takes the newest sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_taps[i] <= '0;
            end
        end else begin
            r_taps[0] <= d;
            for (int i = 1; i < LATENCY; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    assign q = r_taps[LATENCY-1];

endmodule

// File: rtl/cone_checker.sv
// Checks a two-stage inverting pipeline: out must equal a delayed by LATENCY
// edges. Waits LATENCY edges after reset (pipeline output is unknown), then
// compares every edge, flagging and counting mismatches.
module cone_checker
    import cone_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int LATENCY = CONE_LATENCY,
    parameter int CNT_W   = CONE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] out,
    input  logic             clear,
    output logic             primed,
    output logic [WIDTH-1:0] mismatch_q,
    output logic             err_flag,
    output logic [CNT_W-1:0] err_count
);

    // Prime counter runs 0 .. LATENCY-1; at least one bit wide.
    localparam int PCW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [PCW-1:0] PRIME_LAST = PCW'(LATENCY - 1);

    cone_state_e      r_state;
    logic [PCW-1:0]   r_prime_cnt;
    logic             r_primed;
    logic [WIDTH-1:0] r_mismatch;
    logic             r_err_flag;
    logic [CNT_W-1:0] r_err_count;

    logic [WIDTH-1:0] w_exp;
    logic [WIDTH-1:0] w_diff;
    logic             w_miss;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cone_delay_line #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_exp_dly (
        .clk (clk),
        .rst (rst),
        .d   (a),
        .q   (w_exp)
    );

    assign w_diff = w_exp ^ out;
    assign w_miss = |w_diff;

    // FSM: prime for LATENCY edges, then compare; clear outranks a same-edge mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= PRIME;
            r_prime_cnt <= '0;
            r_primed    <= 1'b0;
            r_mismatch  <= '0;
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                PRIME: begin
                    // clear is ignored here; priming simply continues
                    if (r_prime_cnt == PRIME_LAST) begin
                        r_state  <= CHECK;
                        r_primed <= 1'b1;
                    end else begin
                        r_prime_cnt <= r_prime_cnt + 1'b1;
                    end
                end
                CHECK, FAULT: begin
                    if (clear) begin
                        r_state     <= CHECK;
                        r_mismatch  <= '0;
                        r_err_flag  <= 1'b0;
                        r_err_count <= '0;
                    end else begin
                        r_mismatch <= w_diff;
                        if (w_miss) begin
                            r_state     <= FAULT;
                            r_err_flag  <= 1'b1;
                            r_err_count <= sat_inc(r_err_count);
                        end
                    end
                end
                default: begin
                    r_state     <= PRIME;
                    r_prime_cnt <= '0;
                    r_primed    <= 1'b0;
                end
            endcase
        end
    end

    assign primed     = r_primed;
    assign mismatch_q = r_mismatch;
    assign err_flag   = r_err_flag;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_cone_checker.sv
// Scoreboard bench for cone_checker (WIDTH=2, LATENCY=2, CNT_W=8).
// Stimulus pushes the expected post-edge outputs; a monitor pops and compares
// them on the falling edge.
module tb_cone_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] a = '0;
    logic [1:0] out = '0;
    logic       clear = 1'b0;
    logic       primed;
    logic [1:0] mismatch_q;
    logic       err_flag;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int         id;
        logic       p;
        logic       f;
        int         c;
        logic [1:0] m;
    } exp_t;

    exp_t sb[$];

    // a driven one and two edges ago since reset release
    logic [1:0] a_d1 = '0;
    logic [1:0] a_d2 = '0;

    cone_checker #(
        .WIDTH   (2),
        .LATENCY (2),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .out        (out),
        .clear      (clear),
        .primed     (primed),
        .mismatch_q (mismatch_q),
        .err_flag   (err_flag),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic logic [1:0] rnd();
        return 2'($urandom_range(0, 3));
    endfunction

    // Drive one edge worth of inputs and queue the outputs expected after it.
    task automatic step(input int id, input logic [1:0] av, input logic [1:0] ov,
                        input logic clr, input logic ep, input logic ef,
                        input int ec, input logic [1:0] em);
        exp_t e;
        a = av;
        out = ov;
        clear = clr;
        @(posedge clk);
        e.id = id;
        e.p  = ep;
        e.f  = ef;
        e.c  = ec;
        e.m  = em;
        sb.push_back(e);
        a_d2 = a_d1;
        a_d1 = av;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Monitor: compare registered outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("t%0d primed", e.id), int'(primed), int'(e.p));
                chk($sformatf("t%0d err_flag", e.id), int'(err_flag), int'(e.f));
                chk($sformatf("t%0d err_count", e.id), int'(err_count), e.c);
                chk($sformatf("t%0d mismatch_q", e.id), int'(mismatch_q), int'(e.m));
            end
        end
    end

    initial begin
        // reset state
        #3;
        chk("rst primed", int'(primed), 0);
        chk("rst err_flag", int'(err_flag), 0);
        chk("rst err_count", int'(err_count), 0);
        chk("rst mismatch_q", int'(mismatch_q), 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: garbage out while priming (clear ignored), then a correct pipeline
        step(1, rnd(), 2'b11, 1'b1, 1'b0, 1'b0, 0, 2'b00);
        step(1, rnd(), 2'b10, 1'b0, 1'b1, 1'b0, 0, 2'b00);
        for (int i = 0; i < 48; i++) begin
            step(1, rnd(), a_d2, 1'b0, 1'b1, 1'b0, 0, 2'b00);
        end

        // T2: single mismatch, out=11 against exp=01
        step(2, 2'b01, a_d2, 1'b0, 1'b1, 1'b0, 0, 2'b00);
        step(2, rnd(), a_d2, 1'b0, 1'b1, 1'b0, 0, 2'b00);
        step(2, rnd(), 2'b11, 1'b0, 1'b1, 1'b1, 1, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step(2, rnd(), a_d2, 1'b0, 1'b1, 1'b1, 1, 2'b00);
        end

        // T3: 300 mismatching edges saturate the counter at 255
        for (int i = 1; i <= 300; i++) begin
            step(3, rnd(), ~a_d2, 1'b0, 1'b1, 1'b1, (1 + i > 255) ? 255 : 1 + i, 2'b11);
        end

        // T4: clear on a mismatching edge wins; next mismatch counts from 1
        step(4, rnd(), ~a_d2, 1'b1, 1'b1, 1'b0, 0, 2'b00);
        step(4, rnd(), a_d2, 1'b0, 1'b1, 1'b0, 0, 2'b00);
        step(4, rnd(), a_d2 ^ 2'b01, 1'b0, 1'b1, 1'b1, 1, 2'b01);

        // T6: count to 7, then async reset mid-cycle
        step(6, rnd(), a_d2, 1'b1, 1'b1, 1'b0, 0, 2'b00);
        for (int i = 1; i <= 7; i++) begin
            step(6, rnd(), a_d2 ^ 2'b10, 1'b0, 1'b1, 1'b1, i, 2'b10);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async primed", int'(primed), 0);
        chk("async err_flag", int'(err_flag), 0);
        chk("async err_count", int'(err_count), 0);
        chk("async mismatch_q", int'(mismatch_q), 0);
        @(negedge clk);
        rst = 1'b0;
        a_d1 = '0;
        a_d2 = '0;
        step(6, rnd(), 2'b11, 1'b0, 1'b0, 1'b0, 0, 2'b00);
        step(6, rnd(), 2'b11, 1'b0, 1'b1, 1'b0, 0, 2'b00);
        step(6, rnd(), a_d2, 1'b0, 1'b1, 1'b0, 0, 2'b00);
        step(6, rnd(), a_d2 ^ 2'b11, 1'b0, 1'b1, 1'b1, 1, 2'b11);

        // bounded drain of the scoreboard
        for (int k = 0; k < 5 && sb.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        chk("drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cone_checker.md
# cone_checker

Receive-side checker for the two-stage inverting register pipelines used in the logic-cone tests. It taps the pipeline's input `a` and output `out`, and predicts `out` as `a` delayed by `LATENCY` clock edges, because two inversions cancel. It flags and counts every mismatch. It sits beside the pipeline in the test harness and gives a sequential consumer whose cones must survive register-level transformation of the design.

## Interface
Parameters:
- `WIDTH`, default 2: data width of `a` and `out`.
- `LATENCY`, default 2: pipeline depth in clock edges; must be ≥ 1.
- `CNT_W`, default 8: width of the mismatch counter.

Ports:
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `a`  input  WIDTH  pipeline input, observed.
- `out`  input  WIDTH  pipeline output, observed.
- `clear`  input  1  synchronous clear of the error state.
- `primed`  output  1  high once comparison is enabled.
- `mismatch_q`  output  WIDTH  registered per-bit XOR of expected and observed values; zero when not comparing.
- `err_flag`  output  1  sticky; set by the first mismatch.
- `err_count`  output  CNT_W  saturating count of mismatching edges.

## Operation
- Delay line: a `LATENCY`-deep shift register of `a`, shifted on every edge, including during PRIME. `exp` is its oldest entry: `a` as captured `LATENCY` edges earlier.
- FSM states: PRIME, CHECK, FAULT.
  - PRIME: a prime counter counts edges after reset release. On the `LATENCY`-th edge the FSM enters CHECK and `primed` rises. No comparison takes place in PRIME, because the pipeline has no reset and its output is X.
  - CHECK: on each edge, compare `out` with `exp`. A mismatch (any bit differs) moves the FSM to FAULT, sets `err_flag`, and increments `err_count`.
  - FAULT: comparison continues; each mismatching edge increments `err_count`. `clear` returns the FSM to CHECK.
- `clear` in CHECK or FAULT zeroes `err_count`, `err_flag` and `mismatch_q`, and the FSM goes to CHECK. A mismatch on the same edge is discarded, because `clear` has priority.
- `clear` in PRIME has no effect; priming continues.
- `err_count` saturates at 2^CNT_W−1 and holds there; it never wraps.
- `mismatch_q` is loaded with `exp ^ out` on every comparing edge.

## Timing
- Reset values: FSM = PRIME; `primed`, `err_flag`, `err_count`, `mismatch_q` and the delay line all 0; prime counter 0.
- Edges 1..`LATENCY` after reset release fill the delay line.
- `primed` is high after edge `LATENCY`. The first comparison happens on edge `LATENCY`+1 and checks `out` against `a` from edge 1.
- Latency from a mismatching `out` sample to updated `err_flag`, `err_count` and `mismatch_q` is one edge; all outputs are registered.
- `rst` asserted mid-operation immediately forces all reset values. Priming restarts fully on release.

## Structure
- Package `cone_pkg`:
  - `cone_state_e` enum (PRIME, CHECK, FAULT).
  - Default constants `CONE_LATENCY = 2` and `CONE_CNT_W = 8`.
- Sub-module `cone_delay_line`:
  - Parameters `WIDTH`, `LATENCY`.
  - Ports `clk`, `rst`, `d`, `q`; async reset to 0.
  - Instantiated once for the expected-value path.
- The FSM, prime counter and saturating counter live in `cone_checker`.

## Test plan
- Correct pipeline, WIDTH=2, LATENCY=2, random `a` for 50 edges → `primed` rises after edge 2; `err_flag`=0 and `err_count`=0 throughout.
- Force `out`=2'b11 while `exp`=2'b01 on a single edge → on the next edge `mismatch_q`=2'b10, `err_flag`=1, `err_count`=1, FSM in FAULT; `err_flag` stays 1 once `out` is correct again.
- Hold a mismatch for 300 edges with CNT_W=8 → `err_count` reaches 255 and holds; no wrap to 0.
- `clear` on the same edge as a mismatch while in FAULT → `err_count`=0, `err_flag`=0, `mismatch_q`=0, FSM in CHECK; the next mismatch gives `err_count`=1.
- Garbage on `out` during edges 1–2 after reset → no count; the first comparison occurs on edge 3.
- Assert `rst` asynchronously mid-cycle while `err_count`=7 → all outputs are 0 immediately, before the next edge; `primed` returns only 2 edges after release.
